// File: rtl/cmd_response_receiver.sv
// cmd_response_receiver: serial-to-parallel receiver for the SD CMD line.
// After a command goes out it hunts for the response start bit, shifts in a
// short (48-bit) or long (136-bit, R2) response, and checks the end bit and CRC7.
// It then holds the result for the control FSM until the session is dropped.
module cmd_response_receiver #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SHORT_LEN      = 48,
  parameter int LONG_LEN       = 136
) (
  input  logic                sd_clock,
  input  logic                reset,
  input  logic                enable_stp_wrapper,
  input  logic                long_response,
  input  logic                cmd_in,
  output logic [LONG_LEN-1:0] pad_response,
  output logic                reception_complete,
  output logic                no_response,
  output logic                crc_error,
  output logic                end_bit_error
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = $clog2(LONG_LEN + 1);

  localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_LEN - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_LEN - 1);
  // CRC window as received-bit indices (start bit is index 0). The short
  // window nominally includes the start bit, but it is always 0 and the CRC
  // register is cleared when it arrives, so starting at index 1 is equivalent.
  // The long window skips the 8-bit header (start, transmission, reserved).
  localparam logic [CNT_W-1:0] CRC_LO_S   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CRC_HI_S   = CNT_W'(SHORT_LEN - 9);
  localparam logic [CNT_W-1:0] CRC_LO_L   = CNT_W'(8);
  localparam logic [CNT_W-1:0] CRC_HI_L   = CNT_W'(LONG_LEN - 9);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_RECEIVE,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t              r_state;
  logic                r_len_sel;
  logic [TO_W-1:0]     r_to_cnt;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [6:0]          r_crc;
  logic [LONG_LEN-2:0] r_shift;
  logic [LONG_LEN-1:0] r_pad;
  logic                r_cmpl;
  logic                r_no_resp;
  logic                r_crc_err;
  logic                r_end_err;

  logic [LONG_LEN-1:0] w_next_shift;
  logic [LONG_LEN-1:0] w_frame;
  logic [CNT_W-1:0]    w_last_idx;
  logic [CNT_W-1:0]    w_crc_lo;
  logic [CNT_W-1:0]    w_crc_hi;
  logic                w_crc_en;
  logic [6:0]          w_crc_next;

  // Serial CRC7, polynomial x^7 + x^3 + 1, MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign w_next_shift = {r_shift, cmd_in};
  assign w_last_idx   = r_len_sel ? LONG_LAST : SHORT_LAST;
  assign w_crc_lo     = r_len_sel ? CRC_LO_L  : CRC_LO_S;
  assign w_crc_hi     = r_len_sel ? CRC_HI_L  : CRC_HI_S;
  assign w_crc_en     = (r_bit_cnt >= w_crc_lo) && (r_bit_cnt <= w_crc_hi);
  assign w_crc_next   = w_crc_en ? crc7_step(r_crc, cmd_in) : r_crc;
  // Short frames are right-aligned with the unused upper bits forced to zero.
  assign w_frame      = r_len_sel ? w_next_shift
                                  : LONG_LEN'(w_next_shift[SHORT_LEN-1:0]);

  // Receive FSM: start-bit hunt, shift/CRC, completion and timeout reporting.
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_len_sel <= 1'b0;
      r_to_cnt  <= '0;
      r_bit_cnt <= '0;
      r_crc     <= '0;
      r_shift   <= '0;
      r_pad     <= '0;
      r_cmpl    <= 1'b0;
      r_no_resp <= 1'b0;
      r_crc_err <= 1'b0;
      r_end_err <= 1'b0;
    end else if ((r_state != S_IDLE) && !enable_stp_wrapper) begin
      // Session dropped: abandon whatever was in flight, report nothing.
      r_state   <= S_IDLE;
      r_to_cnt  <= '0;
      r_bit_cnt <= '0;
      r_crc     <= '0;
      r_pad     <= '0;
      r_cmpl    <= 1'b0;
      r_no_resp <= 1'b0;
      r_crc_err <= 1'b0;
      r_end_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable_stp_wrapper) begin
            r_len_sel <= long_response;
            r_to_cnt  <= '0;
            r_shift   <= '0;
            r_state   <= S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (!cmd_in) begin
            // Start bit wins even on the edge that would have timed out.
            r_shift   <= w_next_shift[LONG_LEN-2:0];
            r_bit_cnt <= CNT_W'(1);
            r_crc     <= '0;
            r_state   <= S_RECEIVE;
          end else begin
            if (r_to_cnt != TO_MAX) begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (r_to_cnt == TO_LAST) begin
              r_state   <= S_TIMEOUT;
              r_no_resp <= 1'b1;
              r_pad     <= '0;
            end
          end
        end
        S_RECEIVE: begin
          r_shift   <= w_next_shift[LONG_LEN-2:0];
          r_bit_cnt <= r_bit_cnt + 1'b1;
          r_crc     <= w_crc_next;
          if (r_bit_cnt == w_last_idx) begin
            // CRC window ended well before the CRC field, so r_crc is final.
            r_state   <= S_DONE;
            r_pad     <= w_frame;
            r_cmpl    <= 1'b1;
            r_end_err <= ~cmd_in;
            r_crc_err <= (r_crc != w_next_shift[7:1]);
          end
        end
        S_DONE, S_TIMEOUT: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pad_response       = r_pad;
  assign reception_complete = r_cmpl;
  assign no_response        = r_no_resp;
  assign crc_error          = r_crc_err;
  assign end_bit_error      = r_end_err;

endmodule

// File: tb/tb_cmd_response_receiver.sv
// Testbench for cmd_response_receiver: expected results are queued when a
// response (or its absence) is driven and compared when the DUT reports.
module tb_cmd_response_receiver;

  logic         sd_clock;
  logic         reset;
  logic         enable_stp_wrapper;
  logic         long_response;
  logic         cmd_in;
  logic [135:0] pad_response;
  logic         reception_complete;
  logic         no_response;
  logic         crc_error;
  logic         end_bit_error;

  cmd_response_receiver #(
    .TIMEOUT_CYCLES(64),
    .SHORT_LEN     (48),
    .LONG_LEN      (136)
  ) dut (
    .sd_clock          (sd_clock),
    .reset             (reset),
    .enable_stp_wrapper(enable_stp_wrapper),
    .long_response     (long_response),
    .cmd_in            (cmd_in),
    .pad_response      (pad_response),
    .reception_complete(reception_complete),
    .no_response       (no_response),
    .crc_error         (crc_error),
    .end_bit_error     (end_bit_error)
  );

  initial sd_clock = 1'b0;
  always #5 sd_clock = ~sd_clock;

  typedef struct {
    logic [135:0] pad;
    logic         cmpl;
    logic         nr;
    logic         crce;
    logic         ende;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference CRC7 (x^7+x^3+1) over frame bits hi..lo, MSB first.
  function automatic logic [6:0] crc7_model(input logic [135:0] v, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = hi; i >= lo; i--) begin
      fb = v[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic exp_t mk_exp(input logic [135:0] pad, input logic cmpl,
                                  input logic nr, input logic crce, input logic ende);
    exp_t e;
    e.pad = pad; e.cmpl = cmpl; e.nr = nr; e.crce = crce; e.ende = ende;
    return e;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge sd_clock);
    cmd_in = b;
    @(posedge sd_clock);
    #1;
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  // Send the top nbits of a len-bit frame, MSB first. Completion must not
  // show up before the final bit has been sampled.
  task automatic send_frame(input logic [135:0] f, input int len, input int nbits);
    for (int j = 0; j < nbits; j++) begin
      send_bit(f[len-1-j]);
      if (j == len - 2) chk("early_cmpl", 136'(reception_complete), 136'd0);
    end
  endtask

  task automatic start_session(input logic l);
    @(negedge sd_clock);
    enable_stp_wrapper = 1'b1;
    long_response      = l;
    cmd_in             = 1'b1;
    @(posedge sd_clock);
    #1;
  endtask

  task automatic end_session();
    @(negedge sd_clock);
    enable_stp_wrapper = 1'b0;
    cmd_in             = 1'b1;
    @(posedge sd_clock);
    #1;
    chk("clr_cmpl", 136'(reception_complete), 136'd0);
    chk("clr_nr",   136'(no_response),        136'd0);
    chk("clr_pad",  pad_response,             136'd0);
  endtask

  task automatic collect(input int budget);
    exp_t e;
    int   n;
    n = 0;
    while (!(reception_complete || no_response) && n < budget) begin
      @(posedge sd_clock);
      #1;
      n++;
    end
    if (!(reception_complete || no_response)) chk("result_wait", 136'd0, 136'd1);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 136'd0, 136'd1);
    end else begin
      e = sb_q.pop_front();
      chk("pad",  pad_response,              e.pad);
      chk("cmpl", 136'(reception_complete),  136'(e.cmpl));
      chk("nr",   136'(no_response),         136'(e.nr));
      chk("crce", 136'(crc_error),           136'(e.crce));
      chk("ende", 136'(end_bit_error),       136'(e.ende));
    end
  endtask

  task automatic short_case(input logic [47:0] f, input logic crce, input logic ende);
    start_session(1'b0);
    send_ones(5);
    sb_q.push_back(mk_exp(136'(f), 1'b1, 1'b0, crce, ende));
    send_frame(136'(f), 48, 48);
    collect(0);
    end_session();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [135:0] f;
    logic [135:0] lf;

    reset              = 1'b1;
    enable_stp_wrapper = 1'b0;
    long_response      = 1'b0;
    cmd_in             = 1'b1;
    repeat (3) @(posedge sd_clock);
    #1;
    chk("rst_pad",  pad_response,             136'd0);
    chk("rst_cmpl", 136'(reception_complete), 136'd0);
    chk("rst_nr",   136'(no_response),        136'd0);
    chk("rst_crce", 136'(crc_error),          136'd0);
    chk("rst_ende", 136'(end_bit_error),      136'd0);
    @(negedge sd_clock);
    reset = 1'b0;

    // Known-good, corrupted-CRC and bad-end-bit short responses.
    short_case(48'h48000001AA87, 1'b0, 1'b0);
    short_case(48'h400000000095 ^ (48'd1 << 20), 1'b1, 1'b0);
    short_case(48'h400000000094, 1'b0, 1'b1);

    // Line stays idle: timeout after exactly 64 high samples.
    start_session(1'b0);
    sb_q.push_back(mk_exp(136'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    send_ones(63);
    chk("nr_early", 136'(no_response), 136'd0);
    send_bit(1'b1);
    collect(0);
    end_session();

    // Start bit on the 64th sample is still a start.
    start_session(1'b0);
    send_ones(63);
    sb_q.push_back(mk_exp(136'h400000000095, 1'b1, 1'b0, 1'b0, 1'b0));
    send_frame(136'h400000000095, 48, 48);
    collect(0);
    end_session();

    // Abort mid-frame, then a clean frame in a fresh session.
    start_session(1'b0);
    send_ones(5);
    send_frame(136'h48000001AA87, 48, 20);
    @(negedge sd_clock);
    enable_stp_wrapper = 1'b0;
    @(posedge sd_clock);
    #1;
    chk("abort_cmpl", 136'(reception_complete), 136'd0);
    chk("abort_pad",  pad_response,             136'd0);
    short_case(48'h48000001AA87, 1'b0, 1'b0);

    // Randomised well-formed short responses with model CRC.
    for (int r = 0; r < 3; r++) begin
      f = '0;
      f[47:46] = 2'b00;
      f[45:40] = 6'($urandom_range(0, 63));
      f[39:8]  = 32'($urandom);
      f[7:1]   = crc7_model(f, 47, 8);
      f[0]     = 1'b1;
      short_case(f[47:0], 1'b0, 1'b0);
    end

    // Long R2 response; long_response flips after arming and must be ignored.
    lf = '0;
    lf[135:128] = 8'h3F;
    lf[127:8]   = 120'd1;
    lf[7:1]     = crc7_model(lf, 127, 8);
    lf[0]       = 1'b1;
    start_session(1'b1);
    long_response = 1'b0;
    send_ones(5);
    sb_q.push_back(mk_exp(lf, 1'b1, 1'b0, 1'b0, 1'b0));
    send_frame(lf, 136, 136);
    collect(0);
    // Reset while holding a completed result.
    @(negedge sd_clock);
    reset = 1'b1;
    @(posedge sd_clock);
    #1;
    chk("rst_done_pad",  pad_response,             136'd0);
    chk("rst_done_cmpl", 136'(reception_complete), 136'd0);
    @(negedge sd_clock);
    reset              = 1'b0;
    enable_stp_wrapper = 1'b0;
    @(posedge sd_clock);
    #1;

    // Reset mid long frame: receiver must restart and later time out cleanly.
    start_session(1'b1);
    send_ones(5);
    send_frame(lf, 136, 30);
    @(negedge sd_clock);
    reset = 1'b1;
    @(posedge sd_clock);
    #1;
    chk("rst_mid_cmpl", 136'(reception_complete), 136'd0);
    chk("rst_mid_nr",   136'(no_response),        136'd0);
    @(negedge sd_clock);
    reset = 1'b0;
    @(posedge sd_clock);
    #1;
    sb_q.push_back(mk_exp(136'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    send_ones(70);
    collect(0);
    end_session();

    chk("sb_drained", 136'(sb_q.size()), 136'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
